inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 56 +++++
 tb/tb_inst_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: PC generation with branch delay slot, stall-held redirect capture and flush override
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic        if_adel,
  output logic [1:0]  fetch_state
);
  localparam logic [1:0] RUN = 2'b00, HOLD = 2'b01, HOLD_BR = 2'b10;
  logic [31:0] pc_q, pc_d, pend_addr_q, pend_addr_d;
  logic ce_q, pend_valid_q, pend_valid_d, capture, br_e, unused;
  logic [1:0] state_q, state_d;
  logic [31:0] br_addr;
  assign br_e = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign unused = ^stall[5:1];
  assign if_to_id_bus = {ce_q, pc_q};
  assign inst_sram_addr = pc_q;
  assign if_adel = ce_q & (pc_q[1:0] != 2'b00);
  assign inst_sram_en = ce_q & ~if_adel;
  assign inst_sram_wen = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign fetch_state = state_q;
  // next PC by priority; a stalled branch is captured once and replayed on release
  always_comb begin
    pc_d = flush ? new_pc : pend_valid_q ? pend_addr_q : br_e ? br_addr : pc_q + 32'd4;
    capture = stall[0] & br_e & ~flush & (state_q != HOLD_BR);
    state_d = (flush | ~stall[0]) ? RUN : (br_e | state_q == HOLD_BR) ? HOLD_BR : HOLD;
    pend_valid_d = (flush | ~stall[0]) ? 1'b0 : (capture | pend_valid_q);
    pend_addr_d = capture ? br_addr : pend_addr_q;
  end
  // state update; pc advances unless stalled, flush always redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= 32'hBFBF_FFFC;
      ce_q <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q <= 32'h0;
      state_q <= RUN;
    end else begin
      ce_q <= 1'b1;
      if (~stall[0] | flush) pc_q <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q <= pend_addr_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard-driven checks of fetch sequencing, delay slot, stall redirect, flush and reset
module tb_inst_fetch;
  logic clk = 0, rst = 1, flush = 0;
  logic [5:0] stall = 0;
  logic [31:0] new_pc = 0;
  logic [32:0] br_bus = 0;
  logic [32:0] if_to_id_bus;
  logic inst_sram_en, if_adel;
  logic [3:0] inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [1:0] fetch_state;
  int nvec = 0, nerr = 0;
  typedef struct {
    logic r; logic [5:0] s; logic f; logic [31:0] np; logic [32:0] br;
    logic [32:0] bus; logic en; logic adel; logic [1:0] st;
  } vec_t;
  vec_t sb[$];
  vec_t v;
  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc), .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata), .if_adel(if_adel),
    .fetch_state(fetch_state)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [5:0] s, input logic f, input logic [31:0] np,
                     input logic be, input logic [31:0] ba, input logic ce, input logic [31:0] pc,
                     input logic en, input logic adel, input logic [1:0] st);
    vec_t e;
    e.r = r; e.s = s; e.f = f; e.np = np; e.br = {be, ba};
    e.bus = {ce, pc}; e.en = en; e.adel = adel; e.st = st;
    sb.push_back(e);
  endtask
  task automatic tick;
    rst = v.r; stall = v.s; flush = v.f; new_pc = v.np; br_bus = v.br;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) add(1, 6'h3f, 1, 32'h1234_5678, 1, 32'hBFC0_0100, 0, 32'hBFBF_FFFC, 0, 0, 2'b00);
    while (sb.size() > 0) begin
      v = sb.pop_front(); tick(); nvec++;
      if (if_to_id_bus !== v.bus || inst_sram_en !== v.en || if_adel !== v.adel || fetch_state !== v.st ||
          inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'h0 || inst_sram_addr !== v.bus[31:0]) begin
        nerr++;
        $display("FAIL reset: bus=%h en=%b adel=%b st=%b wen=%h wd=%h required bus=%h en=%b adel=%b st=%b wen=0 wd=0",
                 if_to_id_bus, inst_sram_en, if_adel, fetch_state, inst_sram_wen, inst_sram_wdata, v.bus, v.en, v.adel, v.st);
      end
    end
  endtask
  task automatic test_seq;
    add(0, 6'b111110, 0, 0, 0, 0, 1, 32'hBFC0_0000, 1, 0, 2'b00);
    add(0, 6'b111110, 0, 0, 0, 0, 1, 32'hBFC0_0004, 1, 0, 2'b00);
    add(0, 6'b000000, 0, 0, 0, 0, 1, 32'hBFC0_0008, 1, 0, 2'b00);
    while (sb.size() > 0) begin
      v = sb.pop_front(); tick(); nvec++;
      if (if_to_id_bus !== v.bus || inst_sram_en !== v.en || if_adel !== v.adel || fetch_state !== v.st || inst_sram_addr !== v.bus[31:0]) begin
        nerr++;
        $display("FAIL seq: bus=%h en=%b adel=%b st=%b required bus=%h en=%b adel=%b st=%b",
                 if_to_id_bus, inst_sram_en, if_adel, fetch_state, v.bus, v.en, v.adel, v.st);
      end
    end
  endtask
  task automatic test_branch;
    add(0, 0, 0, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0100, 1, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0104, 1, 0, 2'b00);
    while (sb.size() > 0) begin
      v = sb.pop_front(); tick(); nvec++;
      if (if_to_id_bus !== v.bus || inst_sram_en !== v.en || if_adel !== v.adel || fetch_state !== v.st) begin
        nerr++;
        $display("FAIL branch: bus=%h en=%b adel=%b st=%b required bus=%h en=%b adel=%b st=%b",
                 if_to_id_bus, inst_sram_en, if_adel, fetch_state, v.bus, v.en, v.adel, v.st);
      end
    end
  endtask
  task automatic test_stall_br;
    add(0, 1, 0, 0, 1, 32'hBFC0_0200, 1, 32'hBFC0_0104, 1, 0, 2'b10);
    add(0, 1, 0, 0, 1, 32'hBFC0_0300, 1, 32'hBFC0_0104, 1, 0, 2'b10);
    add(0, 1, 0, 0, 0, 0, 1, 32'hBFC0_0104, 1, 0, 2'b10);
    add(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0200, 1, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0204, 1, 0, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, 32'hBFC0_0204, 1, 0, 2'b01);
    add(0, 1, 0, 0, 1, 32'hBFC0_0400, 1, 32'hBFC0_0204, 1, 0, 2'b10);
    add(0, 0, 0, 0, 1, 32'hBFC0_0500, 1, 32'hBFC0_0400, 1, 0, 2'b00);
    while (sb.size() > 0) begin
      v = sb.pop_front(); tick(); nvec++;
      if (if_to_id_bus !== v.bus || inst_sram_en !== v.en || if_adel !== v.adel || fetch_state !== v.st) begin
        nerr++;
        $display("FAIL stall_br: bus=%h en=%b adel=%b st=%b required bus=%h en=%b adel=%b st=%b",
                 if_to_id_bus, inst_sram_en, if_adel, fetch_state, v.bus, v.en, v.adel, v.st);
      end
    end
  endtask
  task automatic test_flush;
    add(0, 1, 0, 0, 1, 32'hBFC0_0600, 1, 32'hBFC0_0400, 1, 0, 2'b10);
    add(0, 1, 1, 32'hBFC0_0380, 1, 32'hBFC0_0700, 1, 32'hBFC0_0380, 1, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0384, 1, 0, 2'b00);
    while (sb.size() > 0) begin
      v = sb.pop_front(); tick(); nvec++;
      if (if_to_id_bus !== v.bus || inst_sram_en !== v.en || if_adel !== v.adel || fetch_state !== v.st) begin
        nerr++;
        $display("FAIL flush: bus=%h en=%b adel=%b st=%b required bus=%h en=%b adel=%b st=%b",
                 if_to_id_bus, inst_sram_en, if_adel, fetch_state, v.bus, v.en, v.adel, v.st);
      end
    end
  endtask
  task automatic test_adel_wrap;
    add(0, 0, 0, 0, 1, 32'hBFC0_0102, 1, 32'hBFC0_0102, 0, 1, 2'b00);
    add(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0106, 0, 1, 2'b00);
    add(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 1, 32'h0000_0004, 1, 0, 2'b00);
    while (sb.size() > 0) begin
      v = sb.pop_front(); tick(); nvec++;
      if (if_to_id_bus !== v.bus || inst_sram_en !== v.en || if_adel !== v.adel || fetch_state !== v.st) begin
        nerr++;
        $display("FAIL adel_wrap: bus=%h en=%b adel=%b st=%b required bus=%h en=%b adel=%b st=%b",
                 if_to_id_bus, inst_sram_en, if_adel, fetch_state, v.bus, v.en, v.adel, v.st);
      end
    end
  endtask
  task automatic test_reset_pending;
    add(0, 1, 0, 0, 1, 32'hBFC0_0800, 1, 32'h0000_0004, 1, 0, 2'b10);
    add(1, 1, 0, 0, 1, 32'hBFC0_0900, 0, 32'hBFBF_FFFC, 0, 0, 2'b00);
    add(0, 1, 1, 32'hBFC0_0040, 0, 0, 1, 32'hBFC0_0040, 1, 0, 2'b00);
    add(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0044, 1, 0, 2'b00);
    while (sb.size() > 0) begin
      v = sb.pop_front(); tick(); nvec++;
      if (if_to_id_bus !== v.bus || inst_sram_en !== v.en || if_adel !== v.adel || fetch_state !== v.st) begin
        nerr++;
        $display("FAIL reset_pending: bus=%h en=%b adel=%b st=%b required bus=%h en=%b adel=%b st=%b",
                 if_to_id_bus, inst_sram_en, if_adel, fetch_state, v.bus, v.en, v.adel, v.st);
      end
    end
  endtask
  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_stall_br();
    test_flush();
    test_adel_wrap();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
